play_timer: RTL

PLAY_TIMER -- requirements
Module: play_timer

---
 rtl/play_timer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/play_timer.sv
// play_timer: playback clock for a song player. Counts elapsed mm:ss in BCD
// while running, counts note advances, and packs everything into a display
// word for the seven-segment scanner.
module play_timer #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    input  logic        song_end,
    input  logic        note_strobe,
    input  logic [3:0]  track,
    output logic [31:0] q_a,
    output logic        running,
    output logic        tick,
    output logic        ovf
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0] TIME_MAX = 16'h9959;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Advance a packed mm:ss BCD time by one second, saturating at 99:59.
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [3:0] s_ones;
        logic [3:0] s_tens;
        logic [3:0] m_ones;
        logic [3:0] m_tens;
        s_ones = t[3:0];
        s_tens = t[7:4];
        m_ones = t[11:8];
        m_tens = t[15:12];
        if (t == TIME_MAX) begin
            // saturate: caller raises ovf
        end else if (s_ones != 4'd9) begin
            s_ones = s_ones + 4'd1;
        end else begin
            s_ones = 4'd0;
            if (s_tens != 4'd5) begin
                s_tens = s_tens + 4'd1;
            end else begin
                s_tens = 4'd0;
                if (m_ones != 4'd9) begin
                    m_ones = m_ones + 4'd1;
                end else begin
                    m_ones = 4'd0;
                    m_tens = m_tens + 4'd1;
                end
            end
        end
        return {m_tens, m_ones, s_tens, s_ones};
    endfunction

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [15:0]     time_q,  time_d;
    logic [7:0]      notes_q, notes_d;
    logic [3:0]      track_q, track_d;
    logic            ovf_q,   ovf_d;
    logic            tick_q,  tick_d;

    // One RUN-cycle worth of progress, used by every branch that lets RUN advance.
    logic            wrap_s;
    logic [PW-1:0]   step_presc_s;
    logic [15:0]     step_time_s;
    logic [7:0]      step_notes_s;
    logic            step_ovf_s;

    // Compute what a RUN cycle would produce if no control pulse intervenes.
    always_comb begin
        wrap_s       = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
        step_presc_s = wrap_s ? {PW{1'b0}} : (presc_q + PW'(1));
        step_time_s  = wrap_s ? bcd_inc(time_q) : time_q;
        step_ovf_s   = ovf_q | (wrap_s && (time_q == TIME_MAX));
        step_notes_s = notes_q + {7'd0, note_strobe};
    end

    // Next-state and datapath update with priority stop > song_end > start > pause.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        time_d  = time_q;
        notes_d = notes_q;
        track_d = track_q;
        ovf_d   = ovf_q;
        tick_d  = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            presc_d = {PW{1'b0}};
            time_d  = 16'h0000;
            notes_d = 8'h00;
            track_d = 4'h0;
            ovf_d   = 1'b0;
        end else if (song_end && ((state_q == ST_RUN) || (state_q == ST_PAUSE))) begin
            state_d = ST_DONE;
            if (state_q == ST_RUN) begin
                // the final note and a coincident second still count
                presc_d = step_presc_s;
                time_d  = step_time_s;
                notes_d = step_notes_s;
                ovf_d   = step_ovf_s;
                tick_d  = wrap_s;
            end else begin
                presc_d = presc_q;
            end
        end else if (start) begin
            state_d = ST_RUN;
            presc_d = {PW{1'b0}};
            time_d  = 16'h0000;
            notes_d = 8'h00;
            track_d = track;
            ovf_d   = 1'b0;
        end else begin
            if (state_q == ST_RUN) begin
                presc_d = step_presc_s;
                time_d  = step_time_s;
                notes_d = step_notes_s;
                ovf_d   = step_ovf_s;
                tick_d  = wrap_s;
            end else begin
                // PAUSE holds the prescaler; IDLE/DONE have nothing to advance
                presc_d = presc_q;
            end
            case (state_q)
                ST_RUN:   state_d = pause ? ST_PAUSE : ST_RUN;
                ST_PAUSE: state_d = pause ? ST_RUN : ST_PAUSE;
                ST_IDLE:  state_d = ST_IDLE;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            presc_q <= {PW{1'b0}};
            time_q  <= 16'h0000;
            notes_q <= 8'h00;
            track_q <= 4'h0;
            ovf_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            time_q  <= time_d;
            notes_q <= notes_d;
            track_q <= track_d;
            ovf_q   <= ovf_d;
            tick_q  <= tick_d;
        end
    end

    assign q_a     = {2'b00, state_q, track_q, notes_q, time_q};
    assign running = (state_q == ST_RUN);
    assign tick    = tick_q;
    assign ovf     = ovf_q;

endmodule
